// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants for the round-robin mux arbiter: requester
//               count, select width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin picker. Rotates req so that ptr lands at bit 0,
//               priority-encodes the lowest set bit, then adds ptr back to
//               recover the absolute requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // req doubled so a plain part-select yields the rotation; the top bit
    // of the second copy can never be reached and is left out.
    logic [2*N_REQ-2:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;

    assign w_dbl = {req[N_REQ-2:0], req};
    assign w_rot = w_dbl[ptr +: N_REQ];

    // Lowest set bit of the rotated vector = distance from ptr to the winner.
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = w_off + ptr;

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 multiplexed output
//               channel between four requesters with a valid/ready stream.
//               Optional macro ARB_HOLD_LIMIT_EN forces release of the grant
//               after MAX_HOLD transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int          DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]        select,
    output logic [DATA_W-1:0]       y,
    output logic                    out_valid,
    output logic                    busy
);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [SEL_W-1:0] r_select;
    logic [SEL_W-1:0] r_ptr;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic [DATA_W-1:0] w_lane [N_REQ];

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    logic [7:0] r_hold_cnt;
    logic       w_xfer;
    assign w_xfer = out_valid & out_ready;
`else
    // Hold limit is compiled out; keep the parameter referenced.
    logic [7:0] w_unused_max_hold;
    assign w_unused_max_hold = 8'(MAX_HOLD);
`endif

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Arbitration FSM: grant on any request, release when the owner drops
    // its request (or hits the hold limit). ptr moves past each new owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_select   <= '0;
            r_ptr      <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= N_REQ'(1) << w_idx;
                        r_select   <= w_idx;
                        r_ptr      <= w_idx + SEL_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!req[r_select]) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    else if (w_xfer) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                        if (r_hold_cnt + 8'd1 == c_max_hold) begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // Split the packed data bus into per-requester lanes.
    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign w_lane[k] = data_in[k*DATA_W +: DATA_W];
    end

    assign gnt       = r_gnt;
    assign select    = r_select;
    assign y         = w_lane[r_select];
    assign busy      = (r_state == ST_GRANT);
    assign out_valid = (r_state == ST_GRANT) & req[r_select];

endmodule
`default_nettype wire
